// File: rtl/rf_wb_if.sv
// Writeback bus between the ALU/load pipeline and the register-file write-port arbiter.
// The master modport is the pipeline side; the slave modport is the arbiter.
interface rf_wb_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) ();
  logic              alu_valid;
  logic [ADDR_W-1:0] alu_wr;
  logic [DATA_W-1:0] alu_data;
  logic              ld_issue;
  logic [ADDR_W-1:0] ld_issue_rd;
  logic              ld_valid;
  logic [ADDR_W-1:0] ld_wr;
  logic [DATA_W-1:0] ld_data;
  logic              ld_ready;
  logic              write_reg;
  logic [ADDR_W-1:0] wr;
  logic [DATA_W-1:0] write;
  logic [31:0]       busy;
  logic              err_waw;

  modport master (
    output alu_valid, alu_wr, alu_data, ld_issue, ld_issue_rd, ld_valid, ld_wr, ld_data,
    input  ld_ready, write_reg, wr, write, busy, err_waw
  );

  modport slave (
    input  alu_valid, alu_wr, alu_data, ld_issue, ld_issue_rd, ld_valid, ld_wr, ld_data,
    output ld_ready, write_reg, wr, write, busy, err_waw
  );
endinterface

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter: ALU writes always win, colliding loads wait in an
// in-order holding queue, and a busy vector tracks registers with loads outstanding.
module rf_wb_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int QDEPTH = 2
) (
  input  logic   clk,
  input  logic   rst,
  rf_wb_if.slave bus
);

  localparam int PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CNT_W = $clog2(QDEPTH + 1);

  logic [ADDR_W-1:0] r_q_addr [QDEPTH];
  logic [DATA_W-1:0] r_q_data [QDEPTH];
  logic [PTR_W-1:0]  r_head;
  logic [PTR_W-1:0]  r_tail;
  logic [CNT_W-1:0]  r_count;
  logic [31:0]       r_busy;
  logic              r_err_waw;

  logic              r_vld_p1;
  logic [ADDR_W-1:0] r_wr_p1;
  logic [DATA_W-1:0] r_write_p1;

  logic              w_ld_ready;
  logic              w_q_empty;
  logic              w_ld_acc;
  logic              w_push;
  logic              w_pop;
  logic              w_grant;
  logic              w_ld_grant;
  logic [ADDR_W-1:0] w_gaddr;
  logic [DATA_W-1:0] w_gdata;
  logic [31:0]       w_busy_nxt;

  // Back-pressure is purely count-based, so a pop does not free a slot until the next cycle.
  assign w_ld_ready = (r_count < CNT_W'(QDEPTH));
  assign w_q_empty  = (r_count == '0);
  assign w_ld_acc   = bus.ld_valid && w_ld_ready;
  assign w_pop      = !bus.alu_valid && !w_q_empty;
  assign w_push     = w_ld_acc && (bus.alu_valid || !w_q_empty);

  always_comb begin
    w_grant    = 1'b0;
    w_ld_grant = 1'b0;
    w_gaddr    = bus.alu_wr;
    w_gdata    = bus.alu_data;
    if (bus.alu_valid) begin
      w_grant = 1'b1;
    end else if (!w_q_empty) begin
      w_grant    = 1'b1;
      w_ld_grant = 1'b1;
      w_gaddr    = r_q_addr[r_head];
      w_gdata    = r_q_data[r_head];
    end else if (w_ld_acc) begin
      w_grant    = 1'b1;
      w_ld_grant = 1'b1;
      w_gaddr    = bus.ld_wr;
      w_gdata    = bus.ld_data;
    end
  end

  // Clear first, then set: a load issued in the same cycle as an older one retires stays busy.
  always_comb begin
    w_busy_nxt = r_busy;
    if (w_ld_grant) w_busy_nxt[w_gaddr] = 1'b0;
    if (bus.ld_issue) w_busy_nxt[bus.ld_issue_rd] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_addr[r_tail] <= bus.ld_wr;
      r_q_data[r_tail] <= bus.ld_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head    <= '0;
      r_tail    <= '0;
      r_count   <= '0;
      r_busy    <= '0;
      r_err_waw <= 1'b0;
    end else begin
      if (w_pop)  r_head <= r_head + PTR_W'(1);
      if (w_push) r_tail <= r_tail + PTR_W'(1);
      if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
      else if (w_pop && !w_push) r_count <= r_count - CNT_W'(1);
      r_busy    <= w_busy_nxt;
      r_err_waw <= r_err_waw | (bus.alu_valid & r_busy[bus.alu_wr]);
    end
  end

  // Stage p1: registered write port to the register file.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld_p1   <= 1'b0;
      r_wr_p1    <= '0;
      r_write_p1 <= '0;
    end else begin
      r_vld_p1 <= w_grant;
      if (w_grant) begin
        r_wr_p1    <= w_gaddr;
        r_write_p1 <= w_gdata;
      end
    end
  end

  assign bus.ld_ready  = w_ld_ready;
  assign bus.write_reg = r_vld_p1;
  assign bus.wr        = r_wr_p1;
  assign bus.write     = r_write_p1;
  assign bus.busy      = r_busy;
  assign bus.err_waw   = r_err_waw;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: expected writebacks are queued in grant order and a
// negedge monitor compares every register-file write against the queue head.
module tb_rf_wb_arbiter;

  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
  } wb_t;

  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;
  wb_t  exp_q[$];
  wb_t  mon_e;

  rf_wb_if #(.DATA_W(32), .ADDR_W(5)) bus ();

  rf_wb_arbiter #(.DATA_W(32), .ADDR_W(5), .QDEPTH(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_wb(input logic [4:0] a, input logic [31:0] d);
    wb_t e;
    e.a = a;
    e.d = d;
    exp_q.push_back(e);
  endtask

  task automatic idle_inputs();
    bus.alu_valid   = 1'b0;
    bus.alu_wr      = '0;
    bus.alu_data    = '0;
    bus.ld_issue    = 1'b0;
    bus.ld_issue_rd = '0;
    bus.ld_valid    = 1'b0;
    bus.ld_wr       = '0;
    bus.ld_data     = '0;
  endtask

  task automatic alu(input logic [4:0] a, input logic [31:0] d);
    bus.alu_valid = 1'b1;
    bus.alu_wr    = a;
    bus.alu_data  = d;
  endtask

  task automatic ld(input logic [4:0] a, input logic [31:0] d);
    bus.ld_valid = 1'b1;
    bus.ld_wr    = a;
    bus.ld_data  = d;
  endtask

  task automatic issue(input logic [4:0] a);
    bus.ld_issue    = 1'b1;
    bus.ld_issue_rd = a;
  endtask

  // Scoreboard monitor: every presented write must match the oldest expected one.
  always @(negedge clk) begin
    if (!rst && bus.write_reg) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: got wr=%0d data=0x%0h expected no write", bus.wr, bus.write);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wb_addr", 64'(bus.wr), 64'(mon_e.a));
        chk("wb_data", 64'(bus.write), 64'(mon_e.d));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish before 100000");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    idle_inputs();
    repeat (2) tick();
    rst = 1'b0;

    // Reset state
    chk("rst_write_reg", 64'(bus.write_reg), 64'd0);
    chk("rst_wr",        64'(bus.wr),        64'd0);
    chk("rst_write",     64'(bus.write),     64'd0);
    chk("rst_busy",      64'(bus.busy),      64'd0);
    chk("rst_ld_ready",  64'(bus.ld_ready),  64'd1);
    chk("rst_err_waw",   64'(bus.err_waw),   64'd0);

    // Single load: issue, return two cycles later, direct write
    issue(5'd5);
    tick();
    idle_inputs();
    chk("t1_busy_set", 64'(bus.busy), 64'h20);
    tick();
    ld(5'd5, 32'hDEADBEEF);
    expect_wb(5'd5, 32'hDEADBEEF);
    chk("t1_busy_before", 64'(bus.busy[5]), 64'd1);
    tick();
    idle_inputs();
    chk("t1_write_reg", 64'(bus.write_reg), 64'd1);
    chk("t1_wr",        64'(bus.wr),        64'd5);
    chk("t1_busy_clr",  64'(bus.busy[5]),   64'd0);
    tick();
    chk("t1_idle", 64'(bus.write_reg), 64'd0);

    // Collision: ALU first, load next cycle
    alu(5'd3, 32'h11);
    ld(5'd7, 32'h22);
    expect_wb(5'd3, 32'h11);
    expect_wb(5'd7, 32'h22);
    chk("t2_ready_pre", 64'(bus.ld_ready), 64'd1);
    tick();
    idle_inputs();
    chk("t2_wr_alu",     64'(bus.wr),       64'd3);
    chk("t2_ready_post", 64'(bus.ld_ready), 64'd1);
    tick();
    chk("t2_wr_ld", 64'(bus.wr), 64'd7);
    tick();
    chk("t2_idle", 64'(bus.write_reg), 64'd0);

    // Back-pressure: four ALU writes while loads r8, r9, r10 arrive
    expect_wb(5'd20, 32'hA0);
    expect_wb(5'd21, 32'hA1);
    expect_wb(5'd22, 32'hA2);
    expect_wb(5'd23, 32'hA3);
    expect_wb(5'd8,  32'h808);
    expect_wb(5'd9,  32'h909);
    expect_wb(5'd10, 32'hA0A);
    alu(5'd20, 32'hA0); ld(5'd8, 32'h808);
    chk("t3_ready0", 64'(bus.ld_ready), 64'd1);
    tick();
    alu(5'd21, 32'hA1); ld(5'd9, 32'h909);
    chk("t3_ready1", 64'(bus.ld_ready), 64'd1);
    tick();
    alu(5'd22, 32'hA2); ld(5'd10, 32'hA0A);
    chk("t3_ready2", 64'(bus.ld_ready), 64'd0);
    tick();
    alu(5'd23, 32'hA3);
    chk("t3_ready3", 64'(bus.ld_ready), 64'd0);
    tick();
    bus.alu_valid = 1'b0;
    chk("t3_ready_pop", 64'(bus.ld_ready), 64'd0);
    tick();
    chk("t3_ready_again", 64'(bus.ld_ready), 64'd1);
    tick();
    bus.ld_valid = 1'b0;
    tick();
    idle_inputs();
    chk("t3_last_wr", 64'(bus.wr), 64'd10);
    tick();
    chk("t3_drained", 64'(bus.ld_ready), 64'd1);

    // Busy set and clear on the same register in the same cycle
    issue(5'd4);
    tick();
    idle_inputs();
    alu(5'd1, 32'h55);
    ld(5'd4, 32'h44);
    expect_wb(5'd1, 32'h55);
    expect_wb(5'd4, 32'h44);
    tick();
    idle_inputs();
    issue(5'd4);
    tick();
    idle_inputs();
    chk("t4_wr_pop",   64'(bus.wr),      64'd4);
    chk("t4_busy_set", 64'(bus.busy[4]), 64'd1);
    ld(5'd4, 32'h45);
    expect_wb(5'd4, 32'h45);
    tick();
    idle_inputs();
    chk("t4_busy_clr", 64'(bus.busy[4]), 64'd0);

    // WAW: ALU writes a busy register
    issue(5'd6);
    tick();
    idle_inputs();
    chk("t5_err_pre", 64'(bus.err_waw), 64'd0);
    alu(5'd6, 32'h66);
    expect_wb(5'd6, 32'h66);
    tick();
    idle_inputs();
    chk("t5_err_set",  64'(bus.err_waw),   64'd1);
    chk("t5_busy_kept", 64'(bus.busy[6]),  64'd1);
    chk("t5_wr",       64'(bus.wr),        64'd6);
    ld(5'd6, 32'h67);
    expect_wb(5'd6, 32'h67);
    tick();
    idle_inputs();
    repeat (2) tick();
    chk("t5_err_sticky", 64'(bus.err_waw), 64'd1);
    chk("t5_busy_clr",   64'(bus.busy),    64'd0);

    // Asynchronous reset with two loads queued and an ALU write in flight
    issue(5'd8);
    tick();
    issue(5'd9);
    tick();
    idle_inputs();
    alu(5'd11, 32'h1); ld(5'd8, 32'h88);
    expect_wb(5'd11, 32'h1);
    tick();
    alu(5'd12, 32'h2); ld(5'd9, 32'h99);
    tick();
    idle_inputs();
    chk("t6_busy_pre",  64'(bus.busy),     64'h300);
    chk("t6_ready_pre", 64'(bus.ld_ready), 64'd0);
    #1 rst = 1'b1;
    #1;
    chk("t6_busy_rst",      64'(bus.busy),      64'd0);
    chk("t6_ready_rst",     64'(bus.ld_ready),  64'd1);
    chk("t6_write_reg_rst", 64'(bus.write_reg), 64'd0);
    chk("t6_err_rst",       64'(bus.err_waw),   64'd0);
    tick();
    rst = 1'b0;
    repeat (4) tick();
    chk("t6_no_writes", 64'(bus.write_reg), 64'd0);
    chk("final_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rf_wb_arbiter.md
# rf_wb_arbiter

Write-port arbiter and load scoreboard for the 32x32 register file. It merges ALU writeback and memory-load writeback onto the register file's single write port (write_reg/wr/write). Loads that collide with an ALU write are held in a small in-order queue. A per-register busy vector lets the decode stage stall on registers that still have a load outstanding.

## Interface
- DATA_W, 32, writeback data width
- ADDR_W, 5, register address width (32 registers)
- QDEPTH, 2, load holding-queue depth (power of two, ≥2)

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- alu_valid  in  1  ALU writeback request this cycle (always granted)
- alu_wr  in  ADDR_W  ALU destination register
- alu_data  in  DATA_W  ALU result
- ld_issue  in  1  load issued; marks ld_issue_rd busy
- ld_issue_rd  in  ADDR_W  destination of issued load
- ld_valid  in  1  load data returning
- ld_wr  in  ADDR_W  load destination register
- ld_data  in  DATA_W  load data
- ld_ready  out  1  load return accepted when ld_valid && ld_ready
- write_reg  out  1  register-file write enable (registered)
- wr  out  ADDR_W  register-file write address (registered)
- write  out  DATA_W  register-file write data (registered)
- busy  out  32  bit r set while a load to register r is outstanding
- err_waw  out  1  sticky: ALU wrote a register whose busy bit was set

## Operation
- Grant priority each cycle:
  1. If alu_valid, grant the ALU.
  2. Otherwise, if the queue is non-empty, grant the queue head (pop).
  3. Otherwise, if a load is accepted, grant the load directly.
  4. Otherwise, no write.
- An accepted load that is not granted directly is pushed to the queue tail. This happens when alu_valid=1, or when the queue is non-empty.
- Pop and push may occur in the same cycle. Order is strictly FIFO, so load writebacks commit in acceptance order.
- ld_ready = (count < QDEPTH), combinational from the queue count. A load is never dropped. When the queue is full, memory holds ld_valid/ld_wr/ld_data stable until ld_ready is high.
- Register 0 gets no special handling; writes to r0 pass through like any other register.
- busy scoreboard:
  - Set: busy[ld_issue_rd] on ld_issue.
  - Clear: busy[r] on the cycle a load writeback to r is granted, whether direct or popped.
  - Same register set and cleared in the same cycle: set wins, because a newer load is outstanding.
  - A clear for a register whose bit is already 0 is ignored.
- err_waw is set when alu_valid && busy[alu_wr] (pre-update value) and holds until reset. The ALU write still proceeds and busy is unchanged.
- Queue count is QDEPTH+1 states wide. Pointers are log2(QDEPTH) bits and wrap modulo QDEPTH.

## Timing
- Reset values: write_reg=0, wr=0, write=0, busy=0, err_waw=0, queue empty, pointers 0. Consequently ld_ready=1.
- Reset asserted mid-operation discards queued loads and clears busy immediately (asynchronous). A write_reg pulse in flight is cancelled.
- Latency:
  - Granted request at edge N appears on write_reg/wr/write during cycle N+1. The register file commits it at edge N+1.
  - Minimum load latency (ld_valid accepted to register-file update) is 2 edges. Each ALU write queued ahead adds one cycle.
- busy reflects clears at the same edge that loads write_reg, so busy[r] drops the cycle write_reg for r is presented. The decode stage must therefore still forward or stall for one cycle, or read after the register file commits.
- write_reg is 0 on any cycle with no grant. wr and write may hold stale values when write_reg=0.
- Queue full with no alu_valid: head pops, but ld_ready stays low that cycle (it is count-based, not pop-aware). The new load is accepted next cycle.

## Test plan
- After reset: write_reg=0, busy=0, ld_ready=1. Sequence: ld_issue rd=5; 2 cycles later ld_valid wr=5 data=0xDEADBEEF; 2nd edge after acceptance has write_reg=1, wr=5, write=0xDEADBEEF → busy[5] 1→0 with that write.
- Collision: alu_valid wr=3 data=0x11 and ld_valid wr=7 data=0x22 in the same cycle → write r3=0x11, next cycle r7=0x22, ld_ready stays 1.
- Back-pressure: alu_valid held 4 cycles while loads r8, r9, r10 arrive → ld_ready drops after 2 accepted. r10 is held; after ALU stops, writes occur in order r8, r9, r10 with no loss.
- Scoreboard: ld_issue rd=4 in the same cycle as the queued writeback to r4 is granted → busy[4] remains 1.
- err_waw: ld_issue rd=6, then alu_valid wr=6 → ALU write occurs, err_waw=1 and stays 1 until rst.
- Async reset with 2 loads queued and busy=0x00000300 → immediately busy=0, ld_ready=1, no further writes.
